// File: rtl/conv_row_scheduler.sv
// Frame sequencer for the row convolution engine: fetches each row, launches one
// engine pass per row, and forwards the captured result row on a valid/ready port.
module conv_row_scheduler #(
  parameter int NUM_ROWS    = 32,
  parameter int ROW_BITS    = 256,
  parameter int RES_N       = 30,
  parameter int RES_W       = 18,
  parameter int TIMEOUT_CYC = 128,
  localparam int IDX_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CNT_W      = $clog2(TIMEOUT_CYC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_timeout,
  output logic                   row_req,
  output logic [IDX_W-1:0]       row_addr,
  input  logic                   row_valid,
  input  logic [ROW_BITS-1:0]    row_data,
  output logic                   eng_start,
  output logic [ROW_BITS-1:0]    eng_row_data,
  input  logic                   eng_done,
  input  logic [RES_N*RES_W-1:0] eng_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_N*RES_W-1:0] res_data,
  output logic [IDX_W-1:0]       res_row_idx,
  output logic                   res_last
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    WAIT_ENG,
    OUTPUT
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       row_q, row_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   frame_done_q, frame_done_d;
  logic [ROW_BITS-1:0]    eng_row_data_q, eng_row_data_d;
  logic [RES_N*RES_W-1:0] res_data_q, res_data_d;
  logic [IDX_W-1:0]       res_row_idx_q, res_row_idx_d;

  logic row_is_last;
  assign row_is_last = (row_q == IDX_W'(NUM_ROWS - 1));

  // NOTE: the wide data registers are reset too, because downstream sees
  // eng_row_data and res_data as outputs that must read zero during reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      row_q          <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      frame_done_q   <= 1'b0;
      eng_row_data_q <= '0;
      res_data_q     <= '0;
      res_row_idx_q  <= '0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      frame_done_q   <= frame_done_d;
      eng_row_data_q <= eng_row_data_d;
      res_data_q     <= res_data_d;
      res_row_idx_q  <= res_row_idx_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    frame_done_d   = 1'b0;
    eng_row_data_d = eng_row_data_q;
    res_data_d     = res_data_q;
    res_row_idx_d  = res_row_idx_q;
    row_req        = 1'b0;
    eng_start      = 1'b0;
    res_valid      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FETCH;
          row_d   = '0;
          err_d   = 1'b0;
        end
      end
      FETCH: begin
        row_req = 1'b1;
        if (row_valid) begin
          eng_row_data_d = row_data;
          state_d        = LAUNCH;
        end
      end
      LAUNCH: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_ENG;
      end
      WAIT_ENG: begin
        // A completion on the final allowed cycle still counts as success.
        if (eng_done) begin
          res_data_d    = eng_result;
          res_row_idx_d = row_q;
          state_d       = OUTPUT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (row_is_last) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            row_d   = row_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;
  assign err_timeout  = err_q;
  assign row_addr     = row_q;
  assign eng_row_data = eng_row_data_q;
  assign res_data     = res_data_q;
  assign res_row_idx  = res_row_idx_q;
  assign res_last     = (state_q == OUTPUT) && row_is_last;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Bench for conv_row_scheduler: line-buffer and engine models feed a result
// scoreboard; each scenario task checks its own observations inline.
module tb_conv_row_scheduler;

  localparam int NR       = 4;
  localparam int ROW_BITS = 256;
  localparam int RES_N    = 30;
  localparam int RES_W    = 18;
  localparam int T        = 128;
  localparam int IDX_W    = 2;
  localparam int RW       = RES_N * RES_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                frame_start = 1'b0;
  logic                busy, frame_done, err_timeout, row_req;
  logic [IDX_W-1:0]    row_addr;
  logic                row_valid;
  logic [ROW_BITS-1:0] row_data;
  logic                eng_start;
  logic [ROW_BITS-1:0] eng_row_data;
  logic                eng_done;
  logic [RW-1:0]       eng_result;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [RW-1:0]       res_data;
  logic [IDX_W-1:0]    res_row_idx;
  logic                res_last;

  conv_row_scheduler #(
    .NUM_ROWS(NR), .ROW_BITS(ROW_BITS), .RES_N(RES_N), .RES_W(RES_W), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .err_timeout(err_timeout), .row_req(row_req),
    .row_addr(row_addr), .row_valid(row_valid), .row_data(row_data),
    .eng_start(eng_start), .eng_row_data(eng_row_data), .eng_done(eng_done),
    .eng_result(eng_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row_idx(res_row_idx), .res_last(res_last)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]    data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  bit eng_silent = 1'b0;
  bit eng_inject = 1'b0;
  bit lb_inject  = 1'b0;
  int eng_delay  = 66;
  int lb_delay   = 0;
  int bench_row  = 0;
  int eng_start_count = 0;
  int fd_count  = 0;
  int res_count = 0;

  function automatic logic [ROW_BITS-1:0] row_pattern(input int r);
    logic [ROW_BITS-1:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(r + 1);
    return v;
  endfunction

  // Element i of row r is i-15 offset by 1000*r, so rows are distinguishable.
  function automatic logic [RW-1:0] build_result(input int r);
    logic [RW-1:0]             v;
    logic signed [RES_W-1:0]   e;
    v = '0;
    for (int i = 0; i < RES_N; i++) begin
      e = RES_W'(i - 15 + 1000 * r);
      v[i*RES_W +: RES_W] = e;
    end
    return v;
  endfunction

  // Line buffer model: answers row_req after lb_delay cycles with row_pattern(row_addr).
  int lb_cnt = 0;
  bit lb_pending = 1'b0;
  initial begin
    row_valid = 1'b0;
    row_data  = '0;
    forever begin
      @(negedge clk);
      if (lb_pending) begin
        total++;
        if (eng_start !== 1'b1) begin
          bad++;
          $display("FAIL row_valid_to_eng_start: eng_start=%b expected 1", eng_start);
        end
        lb_pending = 1'b0;
      end
      row_valid = 1'b0;
      row_data  = {8{32'hDEADBEEF}};
      if (rst) lb_cnt = 0;
      else if (lb_inject) begin
        row_valid = 1'b1;
        row_data  = {8{32'h5A5AA5A5}};
      end else if (row_req === 1'b1) begin
        if (lb_cnt >= lb_delay) begin
          row_valid  = 1'b1;
          row_data   = row_pattern(int'(row_addr));
          lb_cnt     = 0;
          lb_pending = 1'b1;
        end else lb_cnt++;
      end else lb_cnt = 0;
    end
  end

  // Engine model: checks eng_row_data every cycle of a pass, answers after
  // eng_delay cycles and pushes the expected result row to the scoreboard.
  bit                  eng_active = 1'b0;
  bit                  done_pending = 1'b0;
  int                  eng_cnt = 0;
  int                  eng_row = 0;
  logic [ROW_BITS-1:0] exp_rd = '0;
  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (done_pending) begin
        total++;
        if (res_valid !== 1'b1) begin
          bad++;
          $display("FAIL eng_done_to_res_valid: res_valid=%b expected 1", res_valid);
        end
        done_pending = 1'b0;
      end
      if (rst) eng_active = 1'b0;
      else begin
        if (eng_inject) begin
          eng_done   = 1'b1;
          eng_result = {RW{1'b1}};
        end
        if (eng_start === 1'b1) begin
          eng_start_count++;
          eng_active = 1'b1;
          eng_cnt    = 0;
          eng_row    = bench_row;
          bench_row++;
          exp_rd     = row_pattern(eng_row);
        end else if (eng_active) eng_cnt++;
        if (eng_active) begin
          total++;
          if (eng_row_data !== exp_rd) begin
            bad++;
            $display("FAIL eng_row_data_stable: row=%0d cyc=%0d got=%h expected=%h",
                     eng_row, eng_cnt, eng_row_data, exp_rd);
          end
          if (err_timeout === 1'b1) eng_active = 1'b0;
          else if (!eng_silent && eng_cnt == eng_delay) begin
            eng_done   = 1'b1;
            eng_result = build_result(eng_row);
            sb.push_back('{data: build_result(eng_row), idx: IDX_W'(eng_row),
                           last: (eng_row == NR - 1)});
            eng_active   = 1'b0;
            done_pending = 1'b1;
          end
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on each new result and checks it is
  // held stable until accepted; tracks frame_done pulses.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   fd_pending = 1'b0;
  initial forever begin
    @(negedge clk);
    if (fd_pending) begin
      total++;
      if (frame_done !== 1'b1) begin
        bad++;
        $display("FAIL frame_done_pulse: frame_done=%b expected 1", frame_done);
      end
      fd_pending = 1'b0;
    end else if (frame_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL frame_done_unexpected: frame_done=1 expected 0");
    end
    if (frame_done === 1'b1) fd_count++;
    if (rst) have_cur = 1'b0;
    else if (res_valid === 1'b1) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_unexpected: res_valid=1 idx=%0d with empty scoreboard", res_row_idx);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          res_count++;
        end
      end
      if (have_cur) begin
        total++;
        if (res_data !== cur.data || res_row_idx !== cur.idx || res_last !== cur.last
            || row_req !== 1'b0) begin
          bad++;
          $display("FAIL res_output: idx=%0d last=%b row_req=%b data=%h expected idx=%0d last=%b row_req=0 data=%h",
                   res_row_idx, res_last, row_req, res_data, cur.idx, cur.last, cur.data);
        end
        if (res_ready === 1'b1) begin
          have_cur = 1'b0;
          if (cur.last) fd_pending = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bench_row   = 0;
    res_count   = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int base;
    int n;
    base = fd_count;
    n = 0;
    while (fd_count == base && n < 3000) begin
      tick();
      n++;
    end
    if (fd_count == base) begin
      total++;
      bad++;
      $display("FAIL %s_frame_done_timeout: waited %0d cycles, expected frame_done", name, n);
    end
  endtask

  task automatic wait_eng_start(input string name);
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (eng_start !== 1'b1) begin
      bad++;
      $display("FAIL %s_eng_start_timeout: eng_start=%b expected 1", name, eng_start);
    end
  endtask

  task automatic wait_res_valid(input string name);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (res_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_res_valid_timeout: res_valid=%b expected 1", name, res_valid);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({busy, frame_done, err_timeout, row_req, row_addr, eng_start, eng_row_data,
         res_valid, res_data, res_row_idx, res_last} !== '0) begin
      bad++;
      $display("FAIL %s: busy=%b fd=%b err=%b req=%b addr=%0d start=%b rv=%b idx=%0d last=%b rowdata_nz=%b resdata_nz=%b expected all 0",
               name, busy, frame_done, err_timeout, row_req, row_addr, eng_start, res_valid,
               res_row_idx, res_last, |eng_row_data, |res_data);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    check_all_zero("reset_initial_outputs");
    rst = 1'b0;
    tick();
    tick();
    check_bit("reset_release_idle_busy", busy, 1'b0);
    check_bit("reset_release_idle_req", row_req, 1'b0);
    eng_silent = 1'b1;
    start_frame();
    wait_eng_start("reset");
    repeat (5) tick();
    check_bit("reset_mid_wait_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_async_mid_wait");
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_bit("reset_after_release_busy", busy, 1'b0);
    check_bit("reset_after_release_req", row_req, 1'b0);
    check_bit("reset_after_release_valid", res_valid, 1'b0);
    eng_silent = 1'b0;
  endtask

  task automatic test_frame();
    int base_st;
    res_ready = 1'b1;
    eng_delay = 66;
    lb_delay  = 0;
    base_st   = eng_start_count;
    start_frame();
    check_bit("frame_start_to_row_req", row_req, 1'b1);
    check_bit("frame_busy", busy, 1'b1);
    check_int("frame_first_addr", int'(row_addr), 0);
    wait_frame_done("frame");
    check_int("frame_result_count", res_count, NR);
    check_int("frame_eng_starts", eng_start_count - base_st, NR);
    check_int("frame_sb_empty", sb.size(), 0);
    check_bit("frame_busy_after", busy, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    int base_st;
    res_ready = 1'b0;
    eng_delay = 40;
    lb_delay  = 2;
    start_frame();
    wait_res_valid("bp");
    base_st = eng_start_count;
    repeat (10) tick();
    check_int("bp_no_new_start", eng_start_count, base_st);
    check_bit("bp_no_row_req", row_req, 1'b0);
    check_bit("bp_valid_held", res_valid, 1'b1);
    res_ready = 1'b1;
    tick();
    check_bit("bp_valid_drops", res_valid, 1'b0);
    check_bit("bp_row_req_next", row_req, 1'b1);
    check_int("bp_next_addr", int'(row_addr), 1);
    wait_frame_done("bp");
    check_int("bp_result_count", res_count, NR);
    check_int("bp_sb_empty", sb.size(), 0);
  endtask

  task automatic test_timeout();
    int base_fd;
    int base_st;
    int n;
    res_ready  = 1'b1;
    eng_silent = 1'b1;
    lb_delay   = 0;
    base_fd    = fd_count;
    base_st    = eng_start_count;
    start_frame();
    wait_eng_start("timeout");
    n = 0;
    while (err_timeout !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check_int("timeout_cycles_after_eng_start", n, T + 1);
    check_bit("timeout_busy", busy, 1'b0);
    repeat (4) tick();
    check_bit("timeout_sticky", err_timeout, 1'b1);
    check_int("timeout_no_frame_done", fd_count, base_fd);
    check_int("timeout_single_start", eng_start_count - base_st, 1);
    // Engine answers on the very last allowed cycle: completion must win.
    eng_silent = 1'b0;
    eng_delay  = T;
    start_frame();
    check_bit("timeout_cleared_on_start", err_timeout, 1'b0);
    wait_frame_done("timeout_boundary");
    check_int("timeout_boundary_results", res_count, NR);
    check_bit("timeout_boundary_no_err", err_timeout, 1'b0);
  endtask

  task automatic test_spurious_inputs();
    int base_st;
    res_ready = 1'b0;
    eng_delay = 66;
    lb_delay  = 0;
    start_frame();
    wait_res_valid("spur");
    base_st     = eng_start_count;
    frame_start = 1'b1;
    lb_inject   = 1'b1;
    eng_inject  = 1'b1;
    tick();
    frame_start = 1'b0;
    lb_inject   = 1'b0;
    eng_inject  = 1'b0;
    repeat (3) tick();
    check_bit("spur_valid_held", res_valid, 1'b1);
    check_int("spur_idx_held", int'(res_row_idx), 0);
    check_bit("spur_no_row_req", row_req, 1'b0);
    check_bit("spur_busy", busy, 1'b1);
    check_int("spur_no_extra_start", eng_start_count, base_st);
    total++;
    if (eng_row_data !== {32{8'h01}}) begin
      bad++;
      $display("FAIL spur_eng_row_data: got=%h expected=%h", eng_row_data, {32{8'h01}});
    end
    res_ready = 1'b1;
    wait_frame_done("spur");
    check_int("spur_result_count", res_count, NR);
    repeat (5) tick();
    check_bit("spur_idle_after", busy, 1'b0);
  endtask

  task automatic test_data_integrity();
    res_ready = 1'b1;
    eng_delay = 33;
    lb_delay  = 1;
    start_frame();
    wait_frame_done("data");
    check_int("data_result_count", res_count, NR);
    check_int("data_elem0_last_row", int'($signed(res_data[0 +: RES_W])), 2985);
    check_int("data_elem29_last_row", int'($signed(res_data[29*RES_W +: RES_W])), 3014);
    total++;
    if (eng_row_data !== {32{8'h04}}) begin
      bad++;
      $display("FAIL data_eng_row_data_last: got=%h expected=%h", eng_row_data, {32{8'h04}});
    end
    check_int("data_sb_empty", sb.size(), 0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back_backpressure();
    test_timeout();
    test_spurious_inputs();
    test_data_integrity();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
